// File: rtl/mem_responder.sv
// Memory-side responder for the RISC CPU bus: a DEPTH x DATA_W storage array
// behind a small FSM that inserts WAIT_STATES cycles and returns a ready pulse.
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshake: rd/wr are levels sampled only in IDLE. A request is accepted
    // on the edge that moves IDLE->WAIT; ready pulses for exactly one cycle
    // on entry to DONE, and DONE is held until both strobes are seen low, so
    // one long strobe cannot be accepted twice.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_wr_d    = op_wr_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd && wr) begin
                    err_d = 1'b1;
                end else if (rd) begin
                    addr_d  = addr;
                    op_wr_d = 1'b0;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end else if (wr) begin
                    if (data_e) begin
                        addr_d  = addr;
                        wdata_d = data_in;
                        op_wr_d = 1'b1;
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Write commits here so a following read sees the new data.
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_out_d = mem[addr_q];
                    end
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!rd && !wr) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_wr_q    <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_wr_q    <= op_wr_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage is never cleared; reset only blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign data_out  = data_out_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: five instances with different wait-state
// settings share one stimulus stream; each test checks only its own instance.
module tb_mem_responder;

    localparam int NI = 5;
    localparam int WS_TAB [NI] = '{0, 1, 2, 3, 15};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] addr = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       data_e = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout [NI];
    logic       rdy  [NI];
    logic       bsy  [NI];
    logic       er   [NI];
    logic [1:0] st   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .DATA_W(8), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(WS_TAB[g])
        ) u_dut (
            .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr),
            .data_e(data_e), .data_in(data_in), .data_out(dout[g]),
            .ready(rdy[g]), .busy(bsy[g]), .err(er[g]), .state_dbg(st[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int idx);
        rst = 1'b1; rd = 1'b0; wr = 1'b0; data_e = 1'b0;
        step();
        check("rst_dout",  32'(dout[idx]), 32'h0);
        check("rst_ready", 32'(rdy[idx]),  32'h0);
        check("rst_busy",  32'(bsy[idx]),  32'h0);
        check("rst_err",   32'(er[idx]),   32'h0);
        check("rst_state", 32'(st[idx]),   32'h0);
        rst = 1'b0;
    endtask

    // Steps until ready (bounded), checking busy before it and the latency.
    task automatic wait_ready(input int idx, input int lat);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 64) begin
            step();
            n++;
            if (rdy[idx] === 1'b1) got = 1'b1;
            else check("busy_in_wait", 32'(bsy[idx]), 32'h1);
        end
        check("ready_seen", 32'(got), 32'h1);
        check("ready_latency", 32'(n), 32'(lat));
        check("busy_at_ready", 32'(bsy[idx]), 32'h1);
    endtask

    task automatic do_req(input int idx, input bit is_wr, input logic [4:0] a,
                          input logic [7:0] d, input int lat, input logic [7:0] exp_dout);
        addr = a; data_in = d; data_e = is_wr; rd = !is_wr; wr = is_wr;
        step();
        check("busy_after_accept", 32'(bsy[idx]), 32'h1);
        rd = 1'b0; wr = 1'b0; data_e = 1'b0;
        wait_ready(idx, lat);
        if (!is_wr) check("read_data", 32'(dout[idx]), 32'(exp_dout));
        step();
        check("idle_busy", 32'(bsy[idx]), 32'h0);
        check("idle_ready", 32'(rdy[idx]), 32'h0);
    endtask

    initial begin
        // Reset mid-write, WAIT_STATES=3 (instance 3)
        do_reset(3);
        do_req(3, 1'b1, 5'd5, 8'h11, 4, 8'h00);
        addr = 5'd5; data_in = 8'hA5; data_e = 1'b1; wr = 1'b1;
        step();
        wr = 1'b0; data_e = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("abort_busy",  32'(bsy[3]), 32'h0);
        check("abort_ready", 32'(rdy[3]), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_ready", 32'(rdy[3]), 32'h0);
        end
        do_req(3, 1'b0, 5'd5, 8'h00, 4, 8'h11);

        // Write then read, WAIT_STATES=1 (instance 1)
        do_reset(1);
        do_req(1, 1'b1, 5'h1F, 8'h3C, 2, 8'h00);
        check("dout_untouched_by_write", 32'(dout[1]), 32'h0);
        do_req(1, 1'b0, 5'h1F, 8'h00, 2, 8'h3C);

        // Zero wait states with a long read strobe (instance 0)
        do_reset(0);
        do_req(0, 1'b1, 5'd0, 8'h81, 1, 8'h00);
        addr = 5'd0; rd = 1'b1;
        step();
        wait_ready(0, 1);
        check("ws0_read_data", 32'(dout[0]), 32'h81);
        for (int i = 0; i < 4; i++) begin
            step();
            check("held_rd_no_ready", 32'(rdy[0]), 32'h0);
            check("held_rd_busy", 32'(bsy[0]), 32'h1);
        end
        rd = 1'b0;
        step();
        check("held_rd_release", 32'(bsy[0]), 32'h0);

        // Illegal requests (instance 1)
        do_reset(1);
        do_req(1, 1'b1, 5'h1F, 8'h5A, 2, 8'h00);
        addr = 5'h1F; data_in = 8'hEE; data_e = 1'b1; rd = 1'b1; wr = 1'b1;
        step();
        check("err_rdwr", 32'(er[1]), 32'h1);
        check("err_rdwr_busy", 32'(bsy[1]), 32'h0);
        check("err_rdwr_ready", 32'(rdy[1]), 32'h0);
        rd = 1'b0; wr = 1'b0;
        step();
        check("err_clear1", 32'(er[1]), 32'h0);
        wr = 1'b1; data_e = 1'b0;
        step();
        check("err_no_de", 32'(er[1]), 32'h1);
        check("err_no_de_busy", 32'(bsy[1]), 32'h0);
        check("err_no_de_ready", 32'(rdy[1]), 32'h0);
        wr = 1'b0;
        step();
        check("err_clear2", 32'(er[1]), 32'h0);
        check("err_clear2_busy", 32'(bsy[1]), 32'h0);
        do_req(1, 1'b0, 5'h1F, 8'h00, 2, 8'h5A);

        // Back-to-back, WAIT_STATES=2 (instance 2)
        do_reset(2);
        do_req(2, 1'b1, 5'd8, 8'h33, 3, 8'h00);
        addr = 5'd7; data_in = 8'h55; data_e = 1'b1; wr = 1'b1;
        step();
        wr = 1'b0; data_e = 1'b0; addr = 5'd8; data_in = 8'hFF;
        wait_ready(2, 3);
        step();
        check("b2b_idle_at_4", 32'(bsy[2]), 32'h0);
        addr = 5'd7; rd = 1'b1;
        step();
        check("b2b_accept_at_5", 32'(bsy[2]), 32'h1);
        rd = 1'b0;
        wait_ready(2, 3);
        check("b2b_read_data", 32'(dout[2]), 32'h55);
        step();
        do_req(2, 1'b0, 5'd8, 8'h00, 3, 8'h33);

        // Max wait, WAIT_STATES=15 (instance 4)
        do_reset(4);
        do_req(4, 1'b1, 5'd3, 8'h9C, 16, 8'h00);
        addr = 5'd3; rd = 1'b1;
        step();
        check("max_busy_accept", 32'(bsy[4]), 32'h1);
        wait_ready(4, 16);
        check("max_read_data", 32'(dout[4]), 32'h9C);
        step();
        check("max_done_busy", 32'(bsy[4]), 32'h1);
        check("max_done_ready", 32'(rdy[4]), 32'h0);
        rd = 1'b0;
        step();
        check("max_release", 32'(bsy[4]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
